sprite_linebuf: RTL
===================

// Module: sprite_linebuf
// PURPOSE
//  Ping-pong sprite line buffer between the sprite scanline renderer and the colour mixer.
//  Renderer writes next-line pixels into one bank while the mixer reads the current line from the other.
//  Read clears each pixel (read-then-clear), so every bank is empty before it is rendered again.
//  Single clock domain (VCLKx8). Pixel pacing comes from a strobe, not from a second clock.
// PARAMETERS
//  XW  9  line address width (512 pixels per bank)
//  PW  4  sprite pixel (pen) width; pen 0 = transparent
// PORTS
//  VCLKx8  in   1   clock; all logic on rising edge
//  RESET   in   1   synchronous, active-high reset
//  SID     in   1   line parity: read bank = SID, write bank = ~SID
//  WE      in   1   renderer write strobe
//  WADR    in   XW  renderer write x position
//  WPIX    in   PW  renderer pen
//  PIXEN   in   1   one-cycle pixel strobe, once per output pixel
//  RADR    in   XW  read x position (sprite h-position), valid with PIXEN
//  SPPT    out  PW  sprite pen to colour mixer
//  BUSY    out  1   reset clear sweep in progress
//  OVRN    out  1   sticky: PIXEN arrived while a read was in flight
// BEHAVIOUR
//  Reset: SPPT=0, OVRN=0, BUSY=1, FSM->CLR, clear counter=0.
//  FSM states: CLR, IDLE, RD, WB.
//   CLR: write 0 to address {ctr[XW], ctr[XW-1:0]} each cycle, covering both banks, 2^(XW+1) cycles.
//        At the last address, BUSY<=0 and FSM->IDLE. WE/PIXEN are ignored and SPPT is held 0.
//   IDLE: on PIXEN: latch rbank=SID and radr=RADR, issue read, ->RD.
//         Exception: if {SID,RADR} equals the previous read, stay in IDLE and hold SPPT.
//   RD: memory data valid; ->WB.
//   WB: SPPT<=rdata; write 0 to {rbank,radr}; ->IDLE.
//  Latency: PIXEN at cycle n -> SPPT updated at the rising edge ending cycle n+2.
//  Minimum PIXEN spacing is 3 cycles. A PIXEN seen in RD or WB is dropped and sets OVRN (cleared only by RESET).
//  Write port: when WE & (WPIX!=0) & ~BUSY, write WPIX to {~SID,WADR}. Pen 0 never writes.
//  Width/wrap: WADR, RADR wrap modulo 2^XW; no carry into the bank bit.
//  Collision-free by construction: writes go to ~SID, reads/clears go to the latched rbank.
//  SID toggling mid-read: the pending clear completes on the latched rbank, never on the new one.
//  RESET mid-operation: aborts any RD/WB, restarts the full CLR sweep.
// CONFIGURATION
//  SPR_PRIO_FIRST_EN defined: a write is suppressed if the target location already holds a nonzero pen.
//   First-written sprite wins; this needs read-before-write on the write port, adding 1 cycle of write latency.
//   Back-to-back writes to the same address are compared against forwarded data.
//  Not defined: last write wins; writes take effect the cycle after WE.
// STRUCTURE
//  Package sprite_pkg: XW, PW defaults, PEN_CLEAR constant (0), FSM state enum {CLR,IDLE,RD,WB}.
//  Sub-module lbuf_dpram: simple dual-port RAM, 2^(XW+1) x PW.
//   Port A: write (renderer; plus read when SPR_PRIO_FIRST_EN is defined).
//   Port B: read / clear-write. Registered read, 1-cycle latency.
// TESTING
//  1. Reset: assert RESET 1 cycle -> BUSY=1 for 1024 cycles, then 0; SPPT=0 throughout.
//     Every address then reads 0.
//  2. SID=0; WE with WADR=0x10, WPIX=5. Then SID=1; PIXEN with RADR=0x10 -> SPPT=5 two cycles later.
//     Re-read of 0x10 after a different address -> SPPT=0 (cleared).
//  3. WE with WPIX=0 over a location holding 7 -> location still reads 7.
//  4. Writes 3 then 9 to the same address:
//     macro off -> later read gives 9; with SPR_PRIO_FIRST_EN -> 3.
//  5. PIXEN on cycles n and n+1 -> second strobe dropped, OVRN=1.
//     Read result of the first strobe is still correct.
//  6. Toggle SID in the cycle after PIXEN -> clear lands on the old bank.
//     New-bank contents are unchanged (write 0xA there beforehand, read back 0xA).

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite line buffer.
//   XW        line address width (512 pixels per bank)
//   PW        sprite pen width; pen 0 is transparent
//   PEN_CLEAR value written back by the read-then-clear path and the reset sweep
//   lb_state_e  controller states
package sprite_pkg;

  localparam int XW = 9;
  localparam int PW = 4;

  localparam logic [PW-1:0] PEN_CLEAR = '0;

  typedef enum logic [1:0] {
    CLR,
    IDLE,
    RD,
    WB
  } lb_state_e;

endpackage

// File: rtl/sprite_linebuf_if.sv
// Renderer/mixer bus of the sprite line buffer.
//   SID    line parity: read bank = SID, write bank = ~SID
//   WE     renderer write strobe, with WADR (x position) and WPIX (pen)
//   PIXEN  one-cycle pixel strobe, with RADR (read x position)
//   SPPT   sprite pen to the colour mixer
//   BUSY   reset clear sweep in progress
//   OVRN   sticky overrun: a pixel strobe arrived while a read was in flight
// master = renderer/mixer side, slave = line buffer.
interface sprite_linebuf_if;
  import sprite_pkg::*;

  logic          SID;
  logic          WE;
  logic [XW-1:0] WADR;
  logic [PW-1:0] WPIX;
  logic          PIXEN;
  logic [XW-1:0] RADR;
  logic [PW-1:0] SPPT;
  logic          BUSY;
  logic          OVRN;

  modport master (
    output SID, WE, WADR, WPIX, PIXEN, RADR,
    input  SPPT, BUSY, OVRN
  );

  modport slave (
    input  SID, WE, WADR, WPIX, PIXEN, RADR,
    output SPPT, BUSY, OVRN
  );

endinterface

// File: rtl/lbuf_dpram.sv
// Dual-port line RAM holding both ping-pong banks (bank = MSB of the address).
//   VCLKx8   clock
//   a_*      port A: renderer write; with SPR_PRIO_FIRST_EN also a registered
//            read used to check whether the target already holds a pen
//   b_*      port B: registered read (1-cycle latency, read-before-write) and
//            clear-write from the controller
// Optional feature macro: SPR_PRIO_FIRST_EN.
module lbuf_dpram
  import sprite_pkg::*;
#(
  parameter int AW = XW + 1,
  parameter int DW = PW
) (
  input  logic          VCLKx8,
`ifdef SPR_PRIO_FIRST_EN
  input  logic [AW-1:0] a_raddr,
  output logic [DW-1:0] a_rdata,
`endif
  input  logic          a_we,
  input  logic [AW-1:0] a_waddr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge VCLKx8) begin
    if (a_we) mem[a_waddr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
    b_rdata <= mem[b_addr];
`ifdef SPR_PRIO_FIRST_EN
    a_rdata <= mem[a_raddr];
`endif
  end

endmodule

// File: rtl/sprite_linebuf.sv
// Ping-pong sprite line buffer between the scanline renderer and the colour mixer.
// The renderer fills bank ~SID while the mixer reads bank SID; every read clears
// the pixel it returns so a bank is empty before it is rendered again.
//   VCLKx8  clock, all logic on the rising edge
//   RESET   synchronous active-high reset; restarts the full clear sweep
//   bus     sprite_linebuf_if.slave (SID, WE/WADR/WPIX, PIXEN/RADR, SPPT, BUSY, OVRN)
// Optional feature macro: SPR_PRIO_FIRST_EN -- first written pen wins; writes
// gain one cycle of latency for the read-before-write check.
//
// state | meaning
// CLR   | reset sweep writing 0 to every address of both banks
// IDLE  | waiting for PIXEN; read address driven straight from the bus
// RD    | read data valid from the RAM
// WB    | pen to SPPT, clear the latched location
module sprite_linebuf
  import sprite_pkg::*;
(
  input  logic              VCLKx8,
  input  logic              RESET,
  sprite_linebuf_if.slave   bus
);

  lb_state_e     state;
  logic [XW:0]   ctr;
  logic          rbank;
  logic [XW-1:0] radr;
  logic          last_vld;
  logic [PW-1:0] sppt_q;
  logic          busy_q;
  logic          ovrn_q;

  logic          a_we;
  logic [XW:0]   a_waddr;
  logic [PW-1:0] a_wdata;
  logic          b_we;
  logic [XW:0]   b_addr;
  logic [PW-1:0] b_rdata;
  logic          wr_req;
  logic          same_rd;

  // A strobe for the pixel just read would find it already cleared, so keep SPPT.
  assign same_rd = last_vld && ({bus.SID, bus.RADR} == {rbank, radr});
  assign wr_req  = bus.WE && (bus.WPIX != PEN_CLEAR) && !busy_q;

  always_ff @(posedge VCLKx8) begin
    if (RESET) begin
      state    <= CLR;
      ctr      <= '0;
      busy_q   <= 1'b1;
      sppt_q   <= PEN_CLEAR;
      ovrn_q   <= 1'b0;
      last_vld <= 1'b0;
      rbank    <= 1'b0;
      radr     <= '0;
    end else begin
      case (state)
        CLR: begin
          ctr <= ctr + 1'b1;
          if (&ctr) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        IDLE: begin
          if (bus.PIXEN && !same_rd) begin
            rbank    <= bus.SID;
            radr     <= bus.RADR;
            last_vld <= 1'b1;
            state    <= RD;
          end
        end
        RD: begin
          if (bus.PIXEN) ovrn_q <= 1'b1;
          state <= WB;
        end
        WB: begin
          if (bus.PIXEN) ovrn_q <= 1'b1;
          sppt_q <= b_rdata;
          state  <= IDLE;
        end
        default: state <= CLR;
      endcase
    end
  end

  // Port B: the IDLE read address comes from the bus so the data is ready in RD;
  // in RD the latched address re-reads the same word, keeping it valid for WB.
  always_comb begin
    b_addr = {rbank, radr};
    b_we   = 1'b0;
    case (state)
      CLR:     begin b_addr = ctr; b_we = 1'b1; end
      IDLE:    b_addr = {bus.SID, bus.RADR};
      WB:      b_we = 1'b1;
      default: ;
    endcase
  end

`ifdef SPR_PRIO_FIRST_EN
  logic          p_vld;
  logic [XW:0]   p_addr;
  logic [PW-1:0] p_pix;
  logic          c_vld;
  logic [XW:0]   c_addr;
  logic [PW-1:0] a_rdata;
  logic          occupied;

  always_ff @(posedge VCLKx8) begin
    if (RESET) begin
      p_vld <= 1'b0;
      c_vld <= 1'b0;
    end else begin
      p_vld <= wr_req;
      c_vld <= a_we;
    end
    p_addr <= {~bus.SID, bus.WADR};
    p_pix  <= bus.WPIX;
    c_addr <= p_addr;
  end

  // The RAM read is read-before-write, so a commit in the previous cycle is not
  // yet visible in a_rdata; forward it by address compare.
  assign occupied = (a_rdata != PEN_CLEAR) || (c_vld && (c_addr == p_addr));
  assign a_we     = p_vld && !occupied;
  assign a_waddr  = p_addr;
  assign a_wdata  = p_pix;
`else
  assign a_we    = wr_req;
  assign a_waddr = {~bus.SID, bus.WADR};
  assign a_wdata = bus.WPIX;
`endif

  lbuf_dpram u_ram (
    .VCLKx8  (VCLKx8),
`ifdef SPR_PRIO_FIRST_EN
    .a_raddr ({~bus.SID, bus.WADR}),
    .a_rdata (a_rdata),
`endif
    .a_we    (a_we),
    .a_waddr (a_waddr),
    .a_wdata (a_wdata),
    .b_we    (b_we),
    .b_addr  (b_addr),
    .b_wdata (PEN_CLEAR),
    .b_rdata (b_rdata)
  );

  assign bus.SPPT = sppt_q;
  assign bus.BUSY = busy_q;
  assign bus.OVRN = ovrn_q;

endmodule
